oem_serializer: RTL and testbench
=================================

// Module: oem_serializer
// PURPOSE
//  Transmit side of the odd/even-memory (OEM) serial link. Reads a 256-byte frame from
//  8 byte-wide memories (4 banks x odd/even, 32 words each) and emits it MSB-first on
//  so_data/so_valid, one bit per clock. It sits between the frame memories and the
//  serial channel that feeds the OEM receiver/deserializer.
// PARAMETERS
//  DATA_W      8   byte width; bits per serial symbol
//  ADDR_W      5   word address width per memory (32 words)
//  NUM_BANKS   4   odd/even bank pairs
//  GAP_CYCLES  0   idle cycles (so_valid=0) inserted between bytes; 0 = continuous stream
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high
//  start       in   1       1-cycle pulse: begin frame; ignored while busy=1
//  mem_addr    out  ADDR_W  word address to all memories
//  odd_rd      out  4       one-hot read strobe, odd memory of bank[i]
//  even_rd     out  4       one-hot read strobe, even memory of bank[i]
//  mem_rdata   in   DATA_W  read data, valid exactly 1 cycle after strobe (externally muxed)
//  so_data     out  1       serial data, MSB first
//  so_valid    out  1       high while so_data carries a transmitted bit
//  busy        out  1       high from cycle after start until tx_done
//  tx_done     out  1       1-cycle pulse after the last bit of byte 255
// BEHAVIOUR
//  - Reset: so_data=0, so_valid=0, busy=0, tx_done=0, odd_rd=0, even_rd=0, mem_addr=0,
//    byte counter=0, FSM=IDLE. Reset mid-frame aborts; no tx_done is produced.
//  - Byte index k=0..255 maps to: bank=k[7:6], mem_addr=k[5:1], sel=k[0]^k[3]
//    (sel=1 -> odd memory, sel=0 -> even memory). Exactly one strobe bit is high per read.
//  - FSM: IDLE -> FETCH (strobe for k=0) -> LOAD (capture mem_rdata into shift reg) ->
//    SHIFT (8 cycles) -> [GAP, GAP_CYCLES cycles, if >0] -> SHIFT ... -> DONE -> IDLE.
//  - Latency: start sampled at edge t; strobe high cycle t+1; first bit on so_valid at t+3.
//  - SHIFT: so_data = shreg[7], shreg <<= 1 each cycle; so_valid=1 for all 8 cycles.
//  - Prefetch: strobe for byte k+1 is issued in bit-6 cycle of byte k (GAP_CYCLES=0) or in
//    the last GAP cycle (GAP_CYCLES>0), so no extra bubble is inserted; k wraps 255 -> 0
//    and no read is issued after byte 255.
//  - GAP_CYCLES=0: so_valid high for exactly 2048 consecutive cycles per frame.
//  - DONE: tx_done=1 for one cycle, busy drops in the same cycle; start in that cycle ignored,
//    start in the next cycle accepted.
//  - start while busy: ignored, no effect on stream. Strobes are never asserted in IDLE.
// CONFIGURATION
//  SKIP_ZERO_EN defined: a fetched byte equal to 0 is sent as 8 idle cycles (so_valid=0,
//    so_data=0) instead of 8 valid bits; timing/length of the frame unchanged.
//  SKIP_ZERO_EN undefined: every byte, including 0x00, is sent with so_valid=1.
// STRUCTURE
//  - oem_pkg: DATA_W/ADDR_W/NUM_BANKS/FRAME_BYTES(256) constants, FSM state enum
//    (IDLE,FETCH,LOAD,SHIFT,GAP,DONE), function byte_to_loc(k) -> {bank,addr,sel}.
//  - Sub-module oem_addr_gen: byte counter k with advance/clear, drives mem_addr and the
//    one-hot odd_rd/even_rd strobes from byte_to_loc. Top holds FSM, bit counter, shreg.
// TESTING
//  1 Reset then start; memories hold k -> byte k: so_valid at t+3, 2048 contiguous valid
//    cycles, deserialized bytes 0x00..0xFF in order, tx_done once, busy low after.
//  2 Strobe check: k=9 -> bank 0, mem_addr=4, sel=0 -> even_rd=4'b0001; k=200 -> bank 3,
//    mem_addr=4, sel=1 -> odd_rd=4'b1000; never two strobe bits high.
//  3 GAP_CYCLES=3, byte pattern 0xA5: each byte 10100101 then exactly 3 so_valid=0 cycles.
//  4 start pulsed every 100 cycles during a frame -> stream identical to test 1.
//  5 reset asserted at bit 3 of byte 17 -> next cycle all outputs 0, no tx_done;
//    new start -> full frame from byte 0.
//  6 SKIP_ZERO_EN with bytes 2 and 5 = 0x00 -> so_valid low for those 8-cycle slots,
//    frame still 2048 bit-cycles long; without macro those slots are valid zeros.

Source files
------------

// File: rtl/oem_pkg.sv
// Shared constants, FSM encodings and byte-index-to-memory-location mapping for the
// odd/even-memory (OEM) serial link.
package oem_pkg;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned ADDR_W      = 5;
   localparam int unsigned NUM_BANKS   = 4;
   localparam int unsigned BANK_W      = 2;
   localparam int unsigned FRAME_BYTES = 256;
   localparam int unsigned IDX_W       = 8;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StFetch = 3'd1;
   localparam logic [2:0] StLoad  = 3'd2;
   localparam logic [2:0] StShift = 3'd3;
   localparam logic [2:0] StGap   = 3'd4;
   localparam logic [2:0] StDone  = 3'd5;

   typedef struct packed {
      logic [BANK_W-1:0] bank;
      logic [ADDR_W-1:0] addr;
      logic              sel;
   } oem_loc_t;

   // Consecutive even/odd pairs swap every 8 bytes so both memories of a bank share the load.
   function automatic oem_loc_t byte_to_loc(input logic [IDX_W-1:0] k);
      oem_loc_t loc;
      loc.bank = k[7:6];
      loc.addr = k[5:1];
      loc.sel  = k[0] ^ k[3];
      return loc;
   endfunction

endpackage

// File: rtl/oem_addr_gen.sv
// Byte counter for the OEM serializer; turns the current (or next) byte index into a word
// address and one-hot odd/even read strobes.
module oem_addr_gen (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear_i,
   input  logic                         advance_i,
   input  logic                         rd_en_i,
   input  logic                         next_i,
   output logic [oem_pkg::IDX_W-1:0]     k_o,
   output logic [oem_pkg::ADDR_W-1:0]    mem_addr_o,
   output logic [oem_pkg::NUM_BANKS-1:0] odd_rd_o,
   output logic [oem_pkg::NUM_BANKS-1:0] even_rd_o
);
   import oem_pkg::*;

   logic [IDX_W-1:0]     k_q, k_d;
   logic [IDX_W-1:0]     rd_idx;
   oem_loc_t             loc;
   logic [NUM_BANKS-1:0] bank_oh;

   always_comb begin
      k_d = k_q;
      if (clear_i) begin
         k_d = '0;
      end else if (advance_i) begin
         k_d = k_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k_q <= '0;
      end else begin
         k_q <= k_d;
      end
   end

   // next_i addresses the byte after the one in flight (prefetch during shifting).
   always_comb begin
      rd_idx           = next_i ? (k_q + IDX_W'(1)) : k_q;
      loc              = byte_to_loc(rd_idx);
      bank_oh          = '0;
      bank_oh[loc.bank] = 1'b1;
      odd_rd_o         = (rd_en_i && loc.sel)  ? bank_oh : '0;
      even_rd_o        = (rd_en_i && !loc.sel) ? bank_oh : '0;
      mem_addr_o       = loc.addr;
      k_o              = k_q;
   end

endmodule

// File: rtl/oem_serializer.sv
// OEM link transmitter: reads a 256-byte frame from the odd/even bank memories and sends it
// MSB-first, one bit per clock. Optional feature macro: SKIP_ZERO_EN (zero bytes sent idle).
module oem_serializer #(
   parameter int unsigned DATA_W     = oem_pkg::DATA_W,
   parameter int unsigned ADDR_W     = oem_pkg::ADDR_W,
   parameter int unsigned NUM_BANKS  = oem_pkg::NUM_BANKS,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_i,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [NUM_BANKS-1:0] odd_rd_o,
   output logic [NUM_BANKS-1:0] even_rd_o,
   input  logic [DATA_W-1:0]    mem_rdata_i,
   output logic                 so_data_o,
   output logic                 so_valid_o,
   output logic                 busy_o,
   output logic                 tx_done_o
);
   import oem_pkg::*;

   localparam int unsigned BitW = $clog2(DATA_W);
   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [BitW-1:0]  BitLast = BitW'(DATA_W - 1);
   localparam logic [BitW-1:0]  BitPre  = BitW'(DATA_W - 2);
   localparam logic [GapW-1:0]  GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IdxLast = IDX_W'(FRAME_BYTES - 1);

   logic [2:0]        state_q, state_d;
   logic [BitW-1:0]   bit_q, bit_d;
   logic [GapW-1:0]   gap_q, gap_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              bypass_q, bypass_d;

   logic              rd_en;
   logic              rd_next;
   logic              k_adv;
   logic              k_clr;
   logic [IDX_W-1:0]  k;
   logic              last_byte;
   logic              shifting;
   logic              cur_msb;

   oem_addr_gen u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (k_clr),
      .advance_i  (k_adv),
      .rd_en_i    (rd_en),
      .next_i     (rd_next),
      .k_o        (k),
      .mem_addr_o (mem_addr_o),
      .odd_rd_o   (odd_rd_o),
      .even_rd_o  (even_rd_o)
   );

   assign last_byte = (k == IdxLast);

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      gap_d    = gap_q;
      shreg_d  = shreg_q;
      bypass_d = 1'b0;
      rd_en    = 1'b0;
      rd_next  = 1'b0;
      k_adv    = 1'b0;
      k_clr    = 1'b0;

      case (state_q)
         StIdle: begin
            if (start_i) begin
               k_clr   = 1'b1;
               state_d = StFetch;
            end
         end

         StFetch: begin
            rd_en   = 1'b1;
            state_d = StLoad;
         end

         StLoad: begin
            shreg_d = mem_rdata_i;
            bit_d   = '0;
            state_d = StShift;
         end

         StShift: begin
            bit_d = bit_q + BitW'(1);
            // After a gap the first bit comes straight from the read data; the rest is kept.
            if (bypass_q) begin
               shreg_d = {mem_rdata_i[DATA_W-2:0], 1'b0};
            end else begin
               shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            end
            if ((GAP_CYCLES == 0) && (bit_q == BitPre) && !last_byte) begin
               rd_en   = 1'b1;
               rd_next = 1'b1;
            end
            if (bit_q == BitLast) begin
               k_adv = 1'b1;
               bit_d = '0;
               if (last_byte) begin
                  state_d = StDone;
               end else if (GAP_CYCLES == 0) begin
                  shreg_d = mem_rdata_i;
               end else begin
                  gap_d   = '0;
                  state_d = StGap;
               end
            end
         end

         StGap: begin
            gap_d = gap_q + GapW'(1);
            if (gap_q == GapLast) begin
               rd_en    = 1'b1;
               bypass_d = 1'b1;
               bit_d    = '0;
               state_d  = StShift;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         bit_q    <= '0;
         gap_q    <= '0;
         shreg_q  <= '0;
         bypass_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bit_q    <= bit_d;
         gap_q    <= gap_d;
         shreg_q  <= shreg_d;
         bypass_q <= bypass_d;
      end
   end

   assign shifting = (state_q == StShift);
   assign cur_msb  = bypass_q ? mem_rdata_i[DATA_W-1] : shreg_q[DATA_W-1];

`ifdef SKIP_ZERO_EN
   logic skip_q;
   logic load_byte;
   logic fetched_zero;
   logic cur_skip;

   always_comb begin
      fetched_zero = (mem_rdata_i == '0);
      load_byte    = (state_q == StLoad) || bypass_q ||
                     (shifting && (bit_q == BitLast) && (GAP_CYCLES == 0));
      cur_skip     = bypass_q ? fetched_zero : skip_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         skip_q <= 1'b0;
      end else if (load_byte) begin
         skip_q <= fetched_zero;
      end
   end

   assign so_valid_o = shifting && !cur_skip;
`else
   assign so_valid_o = shifting;
`endif

   assign so_data_o = so_valid_o && cur_msb;
   assign busy_o    = (state_q != StIdle) && (state_q != StDone);
   assign tx_done_o = (state_q == StDone);

endmodule

// File: tb/tb_oem_serializer.sv
// Directed self-checking bench for oem_serializer: a continuous-stream instance and a
// GAP_CYCLES=3 instance, each fed by a behavioural frame memory.
module tb_oem_serializer;

`ifdef SKIP_ZERO_EN
   localparam bit Skip = 1'b1;
`else
   localparam bit Skip = 1'b0;
`endif

   typedef struct packed {
      logic done;
      logic busy;
      logic valid;
      logic data;
      logic rd;
   } ent_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start0, start1;
   logic [4:0] addr0, addr1;
   logic [3:0] odd0, even0, odd1, even1;
   logic [7:0] rdata0 = '0;
   logic [7:0] rdata1 = '0;
   logic       sd0, sv0, busy0, done0;
   logic       sd1, sv1, busy1, done1;

   logic [7:0]  mem0 [256];
   logic [7:0]  mem1 [256];
   ent_t        log0 [$];
   ent_t        log1 [$];
   logic [12:0] rd0 [$];
   int          onehot_err = 0;
   int          idle_err   = 0;
   int          checks     = 0;
   int          errors     = 0;

   oem_serializer #(.GAP_CYCLES(0)) u_dut0 (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start0),
      .mem_addr_o  (addr0),
      .odd_rd_o    (odd0),
      .even_rd_o   (even0),
      .mem_rdata_i (rdata0),
      .so_data_o   (sd0),
      .so_valid_o  (sv0),
      .busy_o      (busy0),
      .tx_done_o   (done0)
   );

   oem_serializer #(.GAP_CYCLES(3)) u_dut1 (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start1),
      .mem_addr_o  (addr1),
      .odd_rd_o    (odd1),
      .even_rd_o   (even1),
      .mem_rdata_i (rdata1),
      .so_data_o   (sd1),
      .so_valid_o  (sv1),
      .busy_o      (busy1),
      .tx_done_o   (done1)
   );

   always #5 clk = ~clk;

   // Inverse of the frame layout: strobed location -> byte index.
   function automatic logic [7:0] model_k(input logic [4:0] a, input logic [3:0] o,
                                          input logic [3:0] e);
      logic [3:0] oh;
      logic [1:0] b;
      logic       s;
      oh = o | e;
      b  = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) b = 2'(i);
      s = |o;
      return {b, a, s ^ a[2]};
   endfunction

   always @(posedge clk) begin
      if ((odd0 | even0) != 4'd0) rdata0 <= mem0[model_k(addr0, odd0, even0)];
      if ((odd1 | even1) != 4'd0) rdata1 <= mem1[model_k(addr1, odd1, even1)];
   end

   always @(posedge clk) begin
      #1;
      log0.push_back(ent_t'({done0, busy0, sv0, sd0, |{odd0, even0}}));
      log1.push_back(ent_t'({done1, busy1, sv1, sd1, |{odd1, even1}}));
      if (|{odd0, even0}) rd0.push_back({addr0, odd0, even0});
      if ($countones({odd0, even0}) > 1 || $countones({odd1, even1}) > 1) onehot_err++;
      if ((|{odd0, even0} && !busy0) || (|{odd1, even1} && !busy1)) idle_err++;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int valid_cnt0(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) n += int'(log0[i].valid);
      return n;
   endfunction

   function automatic int done_cnt0(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) n += int'(log0[i].done);
      return n;
   endfunction

   // Slots of the continuous-stream frame whose bits or valid count disagree with mem0.
   function automatic int frame_errs(input int base);
      int errs = 0;
      for (int j = 0; j < 256; j++) begin
         logic [7:0] b;
         int         nv;
         int         exp_nv;
         b  = '0;
         nv = 0;
         for (int i = 0; i < 8; i++) begin
            b  = {b[6:0], log0[base + 2 + 8 * j + i].data};
            nv += int'(log0[base + 2 + 8 * j + i].valid);
         end
         exp_nv = (Skip && mem0[j] == 8'h00) ? 0 : 8;
         if (b != mem0[j] || nv != exp_nv) errs++;
      end
      return errs;
   endfunction

   task automatic test_reset();
      reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
      cycles(3);
      checks++;
      if ({sv0, sd0, busy0, done0, odd0, even0, addr0} !== 17'd0) begin
         errors++; $display("FAIL reset_outputs_dut0 got %h want 0",
                            {sv0, sd0, busy0, done0, odd0, even0, addr0});
      end
      checks++;
      if ({sv1, sd1, busy1, done1, odd1, even1, addr1} !== 17'd0) begin
         errors++; $display("FAIL reset_outputs_dut1 got %h want 0",
                            {sv1, sd1, busy1, done1, odd1, even1, addr1});
      end
      reset = 1'b0;
      cycles(2);
      checks++;
      if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy0); end
   endtask

   task automatic test_frame();
      int base, rbase, base2, nreads, zeros, exp_valid, got;
      for (int k = 0; k < 256; k++) mem0[k] = 8'(k);
      zeros = 0;
      for (int k = 0; k < 256; k++) if (mem0[k] == 8'h00) zeros++;
      exp_valid = Skip ? 2048 - 8 * zeros : 2048;
      @(negedge clk); start0 = 1'b1; base = log0.size(); rbase = rd0.size();
      @(negedge clk); start0 = 1'b0;
      cycles(2050);
      nreads = rd0.size() - rbase;
      // start held across the DONE cycle and the following IDLE cycle
      start0 = 1'b1;
      cycles(2);
      start0 = 1'b0;

      checks++;
      if (log0[base].rd !== 1'b1 || log0[base].busy !== 1'b1) begin
         errors++; $display("FAIL fetch_cycle rd=%b busy=%b want 1 1", log0[base].rd,
                            log0[base].busy);
      end
      checks++;
      if (log0[base + 1].valid !== 1'b0 || log0[base + 2].valid !== 1'b1) begin
         errors++; $display("FAIL first_bit_latency t+2=%b t+3=%b want 0 1",
                            log0[base + 1].valid, log0[base + 2].valid);
      end
      got = valid_cnt0(base + 2, base + 2049);
      checks++;
      if (got !== exp_valid) begin
         errors++; $display("FAIL frame_valid_cycles got %0d want %0d", got, exp_valid);
      end
      got = frame_errs(base);
      checks++;
      if (got !== 0) begin errors++; $display("FAIL frame_bytes bad_slots %0d want 0", got); end
      checks++;
      if (log0[base + 2050].done !== 1'b1 || log0[base + 2050].busy !== 1'b0) begin
         errors++; $display("FAIL done_cycle done=%b busy=%b want 1 0",
                            log0[base + 2050].done, log0[base + 2050].busy);
      end
      got = done_cnt0(base, base + 2051);
      checks++;
      if (got !== 1) begin errors++; $display("FAIL tx_done_count got %0d want 1", got); end
      checks++;
      if (log0[base + 2051].busy !== 1'b0) begin
         errors++; $display("FAIL start_in_done_ignored busy=%b want 0", log0[base + 2051].busy);
      end
      checks++;
      if (log0[base + 2052].busy !== 1'b1) begin
         errors++; $display("FAIL start_after_done busy=%b want 1", log0[base + 2052].busy);
      end
      checks++;
      if (nreads !== 256) begin errors++; $display("FAIL read_count got %0d want 256", nreads); end
      checks++;
      if (rd0[rbase + 9] !== {5'd4, 4'b0000, 4'b0001}) begin
         errors++; $display("FAIL strobe_k9 got %h want %h", rd0[rbase + 9],
                            {5'd4, 4'b0000, 4'b0001});
      end
      checks++;
      if (rd0[rbase + 200] !== {5'd4, 4'b1000, 4'b0000}) begin
         errors++; $display("FAIL strobe_k200 got %h want %h", rd0[rbase + 200],
                            {5'd4, 4'b1000, 4'b0000});
      end

      base2 = base + 2052;
      cycles(2052);
      got = frame_errs(base2);
      checks++;
      if (got !== 0) begin errors++; $display("FAIL restart_frame bad_slots %0d want 0", got); end
      checks++;
      if (log0[base2 + 2050].done !== 1'b1) begin
         errors++; $display("FAIL restart_done got %b want 1", log0[base2 + 2050].done);
      end
   endtask

   task automatic test_gap();
      int         base, bad_bytes, bad_gaps, done_at, got;
      logic [7:0] b;
      for (int k = 0; k < 256; k++) mem1[k] = 8'hA5;
      @(negedge clk); start1 = 1'b1; base = log1.size();
      @(negedge clk); start1 = 1'b0;
      cycles(2830);
      done_at = base + 2 + 256 * 8 + 255 * 3;
      checks++;
      if (log1[base + 1].valid !== 1'b0 || log1[base + 2].valid !== 1'b1) begin
         errors++; $display("FAIL gap_first_bit t+2=%b t+3=%b want 0 1",
                            log1[base + 1].valid, log1[base + 2].valid);
      end
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], log1[base + 2 + i].data};
      checks++;
      if (b !== 8'hA5) begin errors++; $display("FAIL gap_byte0 got %h want a5", b); end
      bad_bytes = 0;
      bad_gaps  = 0;
      for (int j = 0; j < 256; j++) begin
         int nv;
         nv = 0;
         b  = '0;
         for (int i = 0; i < 8; i++) begin
            b  = {b[6:0], log1[base + 2 + 11 * j + i].data};
            nv += int'(log1[base + 2 + 11 * j + i].valid);
         end
         if (b != 8'hA5 || nv != 8) bad_bytes++;
         if (j < 255) begin
            for (int g = 8; g < 11; g++) if (log1[base + 2 + 11 * j + g].valid) bad_gaps++;
         end
      end
      checks++;
      if (bad_bytes !== 0) begin errors++; $display("FAIL gap_bytes bad %0d want 0", bad_bytes); end
      checks++;
      if (bad_gaps !== 0) begin errors++; $display("FAIL gap_idle bad %0d want 0", bad_gaps); end
      checks++;
      if (log1[done_at].done !== 1'b1 || log1[done_at - 1].done !== 1'b0) begin
         errors++; $display("FAIL gap_done at=%b before=%b want 1 0", log1[done_at].done,
                            log1[done_at - 1].done);
      end
      checks++;
      if (log1[done_at + 1].busy !== 1'b0) begin
         errors++; $display("FAIL gap_busy_after got %b want 0", log1[done_at + 1].busy);
      end
   endtask

   task automatic test_start_busy();
      int base, got;
      for (int k = 0; k < 256; k++) mem0[k] = 8'(k);
      @(negedge clk); start0 = 1'b1; base = log0.size();
      @(negedge clk); start0 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycles(99); start0 = 1'b1;
         cycles(1);  start0 = 1'b0;
      end
      cycles(60);
      got = frame_errs(base);
      checks++;
      if (got !== 0) begin errors++; $display("FAIL busy_start_frame bad_slots %0d want 0", got); end
      got = done_cnt0(base, base + 2059);
      checks++;
      if (got !== 1 || log0[base + 2050].done !== 1'b1) begin
         errors++; $display("FAIL busy_start_done count %0d at_end %b want 1 1", got,
                            log0[base + 2050].done);
      end
      checks++;
      if (log0[base + 2055].busy !== 1'b0) begin
         errors++; $display("FAIL busy_start_after got %b want 0", log0[base + 2055].busy);
      end
   endtask

   task automatic test_reset_mid();
      int base, base2, got;
      @(negedge clk); start0 = 1'b1; base = log0.size();
      @(negedge clk); start0 = 1'b0;
      cycles(141);
      reset = 1'b1;
      checks++;
      if (log0[base + 141].valid !== 1'b1) begin
         errors++; $display("FAIL abort_bit3_valid got %b want 1", log0[base + 141].valid);
      end
      cycles(1);
      reset = 1'b0;
      checks++;
      if ({sv0, sd0, busy0, done0, odd0, even0, addr0} !== 17'd0) begin
         errors++; $display("FAIL abort_outputs got %h want 0",
                            {sv0, sd0, busy0, done0, odd0, even0, addr0});
      end
      cycles(2100);
      got = done_cnt0(base, base + 2100);
      checks++;
      if (got !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", got); end
      @(negedge clk); start0 = 1'b1; base2 = log0.size();
      @(negedge clk); start0 = 1'b0;
      cycles(2055);
      got = frame_errs(base2);
      checks++;
      if (got !== 0) begin errors++; $display("FAIL abort_new_frame bad_slots %0d want 0", got); end
   endtask

   task automatic test_zero_bytes();
      int base, got, exp_slot, exp_total;
      for (int k = 0; k < 256; k++) mem0[k] = 8'((k % 255) + 1);
      mem0[2] = 8'h00;
      mem0[5] = 8'h00;
      exp_slot  = Skip ? 0 : 8;
      exp_total = Skip ? 2048 - 16 : 2048;
      @(negedge clk); start0 = 1'b1; base = log0.size();
      @(negedge clk); start0 = 1'b0;
      cycles(2055);
      got = valid_cnt0(base + 2 + 16, base + 2 + 23);
      checks++;
      if (got !== exp_slot) begin
         errors++; $display("FAIL zero_slot2_valid got %0d want %0d", got, exp_slot);
      end
      got = valid_cnt0(base + 2 + 40, base + 2 + 47);
      checks++;
      if (got !== exp_slot) begin
         errors++; $display("FAIL zero_slot5_valid got %0d want %0d", got, exp_slot);
      end
      got = valid_cnt0(base + 2 + 24, base + 2 + 31);
      checks++;
      if (got !== 8) begin errors++; $display("FAIL zero_slot3_valid got %0d want 8", got); end
      got = valid_cnt0(base + 2, base + 2049);
      checks++;
      if (got !== exp_total) begin
         errors++; $display("FAIL zero_total_valid got %0d want %0d", got, exp_total);
      end
      got = frame_errs(base);
      checks++;
      if (got !== 0) begin errors++; $display("FAIL zero_frame bad_slots %0d want 0", got); end
      checks++;
      if (log0[base + 2050].done !== 1'b1) begin
         errors++; $display("FAIL zero_frame_len done=%b want 1", log0[base + 2050].done);
      end
   endtask

   task automatic test_strobes();
      checks++;
      if (onehot_err !== 0) begin
         errors++; $display("FAIL strobe_onehot violations %0d want 0", onehot_err);
      end
      checks++;
      if (idle_err !== 0) begin
         errors++; $display("FAIL strobe_idle violations %0d want 0", idle_err);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_gap();
      test_start_busy();
      test_reset_mid();
      test_zero_bytes();
      test_strobes();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
